ldpc_bitflip_dec: RTL and testbench
===================================

LDPC_BITFLIP_DEC -- requirements
Module: ldpc_bitflip_dec

Interface
REQ-001 SHALL have parameter N, default 11, meaning codeword length in bits.
REQ-002 SHALL have parameter K, default 6, meaning info length; M = N-K parity checks are derived and are not a separate parameter.
REQ-003 SHALL have parameter MAX_ITER, default 8, meaning the maximum number of bit-flip iterations (range 1..255).
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports are listed below in order, clock and reset first.
REQ-005 clk  input  1  system clock; all state is updated on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_en  input  1  start strobe; codeword_in is sampled when i_en is high and the block is accepting.
REQ-008 codeword_in  input  N  received hard-decision word; the info bits occupy [N-1:N-K].
REQ-009 parity_check  input  M*N  flattened H; row r occupies [(M-1-r)*N +: N], so row 0 is at the MSBs; bit j of a row corresponds to codeword bit j.
REQ-010 decoded  output  N  corrected codeword.
REQ-011 info_out  output  K  decoded[N-1:N-K].
REQ-012 o_valid  output  1  result is valid; held high until the next accepted start.
REQ-013 o_busy  output  1  decode is in progress.
REQ-014 o_success  output  1  final syndrome is zero; meaningful only while o_valid is high.
REQ-015 iter_count  output  8  number of flip iterations performed.
REQ-016 flip_total  output  16  cumulative count of flipped bits (see Configuration).

Function
REQ-017 SHALL implement the FSM states IDLE, SYND, FLIP and DONE.
REQ-018 IDLE or DONE, with i_en=1: SHALL latch codeword_in into the working register, clear iter_count, drop o_valid, and go to SYND.
REQ-019 SHALL ignore i_en while in SYND or FLIP; the working register SHALL NOT change.
REQ-020 SYND: SHALL compute s[r] = XOR over j of (H[r][j] AND word[j]) in one cycle; if s == 0, go to DONE with o_success=1.
REQ-021 SYND: if s != 0 and iter_count == MAX_ITER, go to DONE with o_success=0.
REQ-022 SYND: if s != 0 and iter_count < MAX_ITER, go to FLIP.
REQ-023 FLIP: for each bit j, SHALL compute u[j] = number of rows r with s[r]=1 and H[r][j]=1.
REQ-024 FLIP: SHALL invert every bit whose u[j] equals max(u) and is greater than 0, ties included.
REQ-025 FLIP: SHALL increment iter_count and return to SYND; if max(u) is 0, SHALL flip nothing and still count the iteration.
REQ-026 Latency: o_valid SHALL rise 2 cycles after the i_en sample edge for a clean word, plus 2 cycles per iteration.
REQ-027 o_busy SHALL be high exactly in SYND and FLIP.
REQ-028 o_valid SHALL be high exactly in DONE.
REQ-029 decoded SHALL track the working register at all times.
REQ-030 Width of u[j] SHALL be ceil(log2(M+1)); iter_count SHALL saturate at MAX_ITER and never wrap.
REQ-031 parity_check SHALL be sampled live each cycle and is required to be stable from i_en until o_valid.

Reset
REQ-032 On rst=1 at a clock edge, SHALL go to IDLE and zero the working register, iter_count, o_valid, o_busy, o_success and flip_total.
REQ-033 Reset asserted mid-decode SHALL abandon the decode; no o_valid pulse SHALL follow.
REQ-034 rst SHALL take priority over i_en in the same cycle.

Configuration
REQ-035 The macro LDPC_DEC_FLIP_STATS_EN, when defined, SHALL add flip_total: a 16-bit saturating counter, incremented in FLIP by the number of bits flipped, and never cleared except by rst.
REQ-036 Without LDPC_DEC_FLIP_STATS_EN, flip_total SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-037 Package ldpc_pkg SHALL hold the state encoding, the default N/K/MAX_ITER constants and the helper that derives the u[j] width.
REQ-038 Sub-module ldpc_syndrome SHALL be purely combinational: inputs word and H; outputs s and the u[] vector. It is shared with future decoders.

Verification
REQ-039 Zero H rows, codeword_in = 0, i_en pulse -> o_valid 2 cycles later, o_success=1, iter_count=0, decoded=0.
REQ-040 Bench H with distinct columns of weight 2 or more, codeword_in = 11'b00000001000 (zero word, bit 3 in error) -> decoded=0, o_success=1, iter_count=1, o_valid at cycle 4.
REQ-041 MAX_ITER=2, an error pattern whose flips oscillate -> o_success=0, iter_count=2, o_valid at cycle 6.
REQ-042 i_en re-pulsed with a new word while o_busy=1 -> ignored; the first result is unchanged.
REQ-043 rst asserted during FLIP -> next cycle state is IDLE with all outputs 0; no o_valid follows until a new i_en.
REQ-044 With LDPC_DEC_FLIP_STATS_EN defined, two back-to-back single-error decodes -> flip_total=2; with the macro undefined -> flip_total=0.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared definitions for the hard-decision LDPC bit-flip decoders:
// FSM encoding, default code dimensions and the u[] counter width helper.
package ldpc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    FLIP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_N        = 11;
  localparam int DEF_K        = 6;
  localparam int DEF_MAX_ITER = 8;

  // Unsatisfied-check counts range over 0..M, so they need ceil(log2(M+1)) bits.
  function automatic int u_width(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ldpc_syndrome.sv
// Combinational syndrome and per-bit unsatisfied-check counter.
// Row r of H sits at h[(M-1-r)*N +: N]; u[j] is packed at u[j*UW +: UW].
module ldpc_syndrome
  import ldpc_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int M  = DEF_N - DEF_K,
  parameter int UW = u_width(DEF_N - DEF_K)
) (
  input  logic [N-1:0]   word,
  input  logic [M*N-1:0] h,
  output logic [M-1:0]   s,
  output logic [N*UW-1:0] u
);

  genvar gi;

  generate
    for (gi = 0; gi < M; gi++) begin : g_row
      assign s[gi] = ^(h[(M-1-gi)*N +: N] & word);
    end

    for (gi = 0; gi < N; gi++) begin : g_col
      logic [UW-1:0] cnt;
      always_comb begin
        cnt = '0;
        for (int r = 0; r < M; r++) begin
          cnt = cnt + UW'(s[r] & h[(M-1-r)*N + gi]);
        end
      end
      assign u[gi*UW +: UW] = cnt;
    end
  endgenerate

endmodule

// File: rtl/ldpc_bitflip_dec.sv
// Iterative hard-decision bit-flip LDPC decoder (SYND/FLIP alternate per iteration).
// Optional flip statistics counter enabled by defining LDPC_DEC_FLIP_STATS_EN.
module ldpc_bitflip_dec
  import ldpc_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int K        = DEF_K,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [N-1:0]       codeword_in,
  input  logic [(N-K)*N-1:0] parity_check,
  output logic [N-1:0]       decoded,
  output logic [K-1:0]       info_out,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_success,
  output logic [7:0]         iter_count,
  output logic [15:0]        flip_total
);

  localparam int M  = N - K;
  localparam int UW = u_width(M);
  localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);

  state_t         state_reg, state_next;
  logic [N-1:0]   word_reg, word_next;
  logic [7:0]     iter_reg, iter_next;
  logic           success_reg, success_next;

  logic [M-1:0]    synd;
  logic [N*UW-1:0] u_vec;
  logic [UW-1:0]   u_max;
  logic [N-1:0]    flip_mask;

  ldpc_syndrome #(
    .N  (N),
    .M  (M),
    .UW (UW)
  ) u_synd (
    .word (word_reg),
    .h    (parity_check),
    .s    (synd),
    .u    (u_vec)
  );

  always_comb begin
    u_max = '0;
    for (int j = 0; j < N; j++) begin
      if (u_vec[j*UW +: UW] > u_max) begin
        u_max = u_vec[j*UW +: UW];
      end
    end
  end

  // Every bit tied for the largest nonzero count flips together.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_flip
      assign flip_mask[gi] = (u_max != '0) && (u_vec[gi*UW +: UW] == u_max);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (i_en) state_next = SYND;
      SYND: begin
        if (synd == '0)                 state_next = DONE;
        else if (iter_reg == ITER_LIMIT) state_next = DONE;
        else                            state_next = FLIP;
      end
      FLIP:    state_next = SYND;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (state_reg == SYND) || (state_reg == FLIP);
    o_valid = (state_reg == DONE);
  end

  always_comb begin
    word_next    = word_reg;
    iter_next    = iter_reg;
    success_next = success_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (i_en) begin
          word_next    = codeword_in;
          iter_next    = '0;
          success_next = 1'b0;
        end
      end
      SYND: if (synd == '0) success_next = 1'b1;
      FLIP: begin
        word_next = word_reg ^ flip_mask;
        if (iter_reg < ITER_LIMIT) iter_next = iter_reg + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg    <= '0;
      iter_reg    <= '0;
      success_reg <= 1'b0;
    end else begin
      word_reg    <= word_next;
      iter_reg    <= iter_next;
      success_reg <= success_next;
    end
  end

  assign decoded    = word_reg;
  assign info_out   = word_reg[N-1:N-K];
  assign o_success  = success_reg;
  assign iter_count = iter_reg;

`ifdef LDPC_DEC_FLIP_STATS_EN
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] flip_cnt;
  logic [15:0]   flip_total_reg;
  logic [16:0]   flip_sum;

  always_comb begin
    flip_cnt = '0;
    for (int j = 0; j < N; j++) begin
      flip_cnt = flip_cnt + CW'(flip_mask[j]);
    end
  end

  assign flip_sum = {1'b0, flip_total_reg} + 17'(flip_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      flip_total_reg <= '0;
    end else if (state_reg == FLIP) begin
      flip_total_reg <= flip_sum[16] ? 16'hFFFF : flip_sum[15:0];
    end
  end

  assign flip_total = flip_total_reg;
`else
  assign flip_total = '0;
`endif

endmodule

// File: tb/tb_ldpc_bitflip_dec.sv
// Scoreboard bench for ldpc_bitflip_dec (N=11, K=6, MAX_ITER=2) with a
// hand-built H whose columns are distinct and of weight 2 or 3.
module tb_ldpc_bitflip_dec;

  localparam int N = 11;
  localparam int K = 6;
  localparam int M = N - K;

  typedef struct {
    logic [10:0] dec;
    logic        succ;
    logic [7:0]  it;
    int          lat;
    logic [15:0] ft;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_en = 1'b0;
  logic [N-1:0]     codeword_in = '0;
  logic [M*N-1:0]   parity_check = '0;
  logic [N-1:0]     decoded;
  logic [K-1:0]     info_out;
  logic             o_valid;
  logic             o_busy;
  logic             o_success;
  logic [7:0]       iter_count;
  logic [15:0]      flip_total;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_ft   = 0;
  exp_t sb[$];

  // Columns: j0{0,1} j1{0,2} j2{1,2} j3{3,4} j4{0,3} j5{0,4} j6{1,3} j7{1,4} j8{2,3} j9{2,4} j10{0,1,2}
  localparam logic [M*N-1:0] H_BENCH = {11'b10000110011, 11'b10011000101,
                                        11'b11100000110, 11'b00101011000,
                                        11'b01010101000};

  ldpc_bitflip_dec #(
    .N        (N),
    .K        (K),
    .MAX_ITER (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (i_en),
    .codeword_in  (codeword_in),
    .parity_check (parity_check),
    .decoded      (decoded),
    .info_out     (info_out),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_success    (o_success),
    .iter_count   (iter_count),
    .flip_total   (flip_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [10:0] dec, input logic succ, input logic [7:0] it,
                              input int lat, input int nflips);
    exp_t e;
`ifdef LDPC_DEC_FLIP_STATS_EN
    exp_ft = (exp_ft + nflips > 65535) ? 65535 : exp_ft + nflips;
`else
    exp_ft = 0 * nflips;
`endif
    e.dec  = dec;
    e.succ = succ;
    e.it   = it;
    e.lat  = lat;
    e.ft   = 16'(exp_ft);
    return e;
  endfunction

  // Cycle index relative to the cycle in which i_en was presented and accepted.
  initial begin
    forever begin
      @(posedge clk);
      if (rst)                cyc = 0;
      else if (i_en && !o_busy) cyc = 1;
      else                    cyc = cyc + 1;
    end
  end

  // Monitor: every rising o_valid consumes one expected result.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(o_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("decoded",   32'(decoded),    32'(e.dec));
          check("info_out",  32'(info_out),   32'(e.dec[10:5]));
          check("success",   32'(o_success),  32'(e.succ));
          check("iter",      32'(iter_count), 32'(e.it));
          check("latency",   32'(cyc),        32'(e.lat));
          check("busy_done", 32'(o_busy),     32'd0);
          check("flip_total", 32'(flip_total), 32'(e.ft));
          $display("result dec=%b succ=%0d iter=%0d lat=%0d ft=%0d",
                   decoded, o_success, iter_count, cyc, flip_total);
        end
      end
      prev_valid = o_valid;
    end
  end

  task automatic start(input logic [10:0] cw, input exp_t e);
    @(negedge clk);
    codeword_in = cw;
    i_en = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    i_en = 1'b0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("result_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(o_valid),    32'd0);
    check({tag, "_busy"},    32'(o_busy),     32'd0);
    check({tag, "_success"}, 32'(o_success),  32'd0);
    check({tag, "_iter"},    32'(iter_count), 32'd0);
    check({tag, "_decoded"}, 32'(decoded),    32'd0);
    check({tag, "_info"},    32'(info_out),   32'd0);
    check({tag, "_ft"},      32'(flip_total), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Zero H: every word is clean.
    parity_check = '0;
    start(11'b00000000000, mk(11'b00000000000, 1'b1, 8'd0, 2, 0));
    wait_result();
    start(11'b10110011010, mk(11'b10110011010, 1'b1, 8'd0, 2, 0));
    wait_result();

    parity_check = H_BENCH;
    start(11'b00000001000, mk(11'b00000000000, 1'b1, 8'd1, 4, 1));
    wait_result();
    start(11'b00000111000, mk(11'b00000111000, 1'b1, 8'd0, 2, 0));
    wait_result();
    start(11'b01000111000, mk(11'b00000111000, 1'b1, 8'd1, 4, 1));
    wait_result();

    // New start while busy must be ignored.
    start(11'b00000001000, mk(11'b00000000000, 1'b1, 8'd1, 4, 1));
    codeword_in = 11'b11111111111;
    i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    wait_result();

    // Syndrome {3}: needs three iterations, so MAX_ITER=2 gives up.
    start(11'b10100000001, mk(11'b00001011001, 1'b0, 8'd2, 6, 5));
    wait_result();

    // Reset while in FLIP abandons the decode.
    @(negedge clk);
    codeword_in = 11'b10100000001;
    i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    @(negedge clk);
    check("busy_in_flip", 32'(o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ft = 0;
    check_reset_outputs("midrst");
    repeat (10) @(negedge clk);
    check("no_valid_after_rst", 32'(o_valid), 32'd0);

    // Two back-to-back single-error decodes after reset.
    start(11'b00000001000, mk(11'b00000000000, 1'b1, 8'd1, 4, 1));
    wait_result();
    start(11'b01000111000, mk(11'b00000111000, 1'b1, 8'd1, 4, 1));
    wait_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
